uart_txq: RTL and testbench

Buffered UART transmitter peripheral for the processor bus: the transmit-side counterpart to the receive-FIFO UART path. CPU writes bytes into a 2^AWIDTH-deep TX FIFO through the standard cs/wen/addr/din/dout register port. An internal 8N1 serializer drains the FIFO onto TxD, LSB first, at a programmable cycles-per-bit rate, with back-to-back frames and no idle gap. Status, sent-character and overflow counters are readable.

---
 rtl/uart_txq.sv | 215 +++++++++++++++++++++
 tb/tb_uart_txq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txq.sv
// Buffered 8N1 UART transmitter: CPU-written TX FIFO drained onto TxD by a
// start/data/stop serializer at a programmable cycles-per-bit rate.
module uart_txq #(
    parameter int WIDTH     = 32,
    parameter int AWIDTH    = 4,
    parameter int CPB_RESET = 216
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cs,
    input  logic             wen,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             TxD
);

    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [3:0] A_DR    = 4'd0;
    localparam logic [3:0] A_CTRL  = 4'd1;
    localparam logic [3:0] A_TSTAT = 4'd2;
    localparam logic [3:0] A_CPB   = 4'd3;
    localparam logic [3:0] A_SENT  = 4'd4;
    localparam logic [3:0] A_OVF   = 4'd5;
    localparam logic [3:0] A_FLUSH = 4'd6;

    // Control / status state
    logic              tx_en;
    logic [WIDTH-1:0]  cpb;
    logic [31:0]       sent_count;
    logic [31:0]       ovf_count;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   level;
    logic [1:0]        state;
    logic [WIDTH-1:0]  bit_tmr;
    logic [2:0]        bit_idx;
    logic              txd_q;

    // Datapath state
    logic [7:0]        fifo_mem [DEPTH];
    logic [7:0]        shift;
    logic [WIDTH-1:0]  cpb_lat;

    logic              wr_en;
    logic              wr_dr;
    logic              wr_ctrl;
    logic              wr_cpb;
    logic              wr_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              push;
    logic              ovf_hit;
    logic              can_load;
    logic              bit_end;
    logic              pop;
    logic [WIDTH-1:0]  cpb_eff;
    logic [7:0]        fifo_head;
    logic [WIDTH-1:0]  tstat;

    assign wr_en    = cs & wen;
    assign wr_dr    = wr_en & (addr == A_DR);
    assign wr_ctrl  = wr_en & (addr == A_CTRL);
    assign wr_cpb   = wr_en & (addr == A_CPB);
    assign wr_flush = wr_en & (addr == A_FLUSH);

    // FULL is taken from the registered level, so a pop in the same cycle
    // never makes room for a push.
    assign fifo_full  = (level == (AWIDTH + 1)'(DEPTH));
    assign fifo_empty = (level == '0);

    assign push_req = wr_dr & tx_en;
    assign push     = push_req & ~fifo_full & ~wr_flush;
    assign ovf_hit  = push_req & fifo_full & ~wr_flush;

    assign can_load  = tx_en & ~fifo_empty;
    assign bit_end   = (bit_tmr == cpb_lat - WIDTH'(1));
    assign pop       = ((state == S_IDLE) & can_load) |
                       ((state == S_STOP) & bit_end & can_load);
    assign cpb_eff   = (cpb == '0) ? WIDTH'(1) : cpb;
    assign fifo_head = fifo_mem[rd_ptr];

    assign TxD = txd_q;

    // Register file and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_en     <= 1'b0;
            cpb       <= WIDTH'(CPB_RESET);
            ovf_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            if (wr_ctrl) tx_en <= din[1];
            if (wr_cpb)  cpb   <= din;
            if (ovf_hit) ovf_count <= ovf_count + 32'd1;
            if (wr_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AWIDTH'(1);
                if (pop)  rd_ptr <= rd_ptr + AWIDTH'(1);
                level <= level + (AWIDTH + 1)'(push) - (AWIDTH + 1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= din[7:0];
    end

    // Serializer control: TxD is registered and changes on the same edge
    // as the state transition that selects its new level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            txd_q      <= 1'b1;
            sent_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (can_load) begin
                        state   <= S_START;
                        bit_tmr <= '0;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_tmr <= '0;
                        bit_idx <= '0;
                        txd_q   <= shift[0];
                    end else begin
                        bit_tmr <= bit_tmr + WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_tmr <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shift[1];
                        end
                    end else begin
                        bit_tmr <= bit_tmr + WIDTH'(1);
                    end
                end
                default: begin
                    if (bit_end) begin
                        sent_count <= sent_count + 32'd1;
                        bit_tmr    <= '0;
                        if (can_load) begin
                            state <= S_START;
                            txd_q <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd_q <= 1'b1;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // Serializer data: the bit period is latched per frame, so CPB writes
    // never disturb a frame already on the wire.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift   <= fifo_head;
            cpb_lat <= cpb_eff;
        end else if ((state == S_DATA) && bit_end) begin
            shift <= shift >> 1;
        end
    end

    always_comb begin
        tstat       = '0;
        tstat[15:8] = 8'(level);
        tstat[3]    = (state != S_IDLE);
        tstat[2]    = fifo_empty;
        tstat[1]    = fifo_full;
        tstat[0]    = fifo_empty & (state == S_IDLE);
    end

    always_comb begin
        dout = '0;
        case (addr)
            A_CTRL:  dout = WIDTH'({tx_en, 1'b0});
            A_TSTAT: dout = tstat;
            A_CPB:   dout = cpb;
            A_SENT:  dout = WIDTH'(sent_count);
            A_OVF:   dout = WIDTH'(ovf_count);
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_txq.sv
// Directed bench for uart_txq: register access, frame waveforms, FIFO limits,
// mid-frame control changes and reset abort.
module tb_uart_txq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cs;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        TxD;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int last_wr = 0;
    logic hist [0:16383];

    uart_txq #(.WIDTH(32), .AWIDTH(4), .CPB_RESET(216)) dut (
        .clk    (clk),
        .resetn (resetn),
        .cs     (cs),
        .wen    (wen),
        .addr   (addr),
        .din    (din),
        .dout   (dout),
        .TxD    (TxD)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; hist[e] = TxD after edge e
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 16384) hist[cyc] = TxD;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wen = 1'b0;
        last_wr = cyc;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        d = dout;
        cs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL reset_tstat: got %h expected %h", r, 32'h5); else n_pass++;
        bus_read(4'd3, r);
        n_total++; if (r !== 32'd216) $display("FAIL reset_cpb: got %0d expected %0d", r, 216); else n_pass++;
        n_total++; if (TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TxD); else n_pass++;
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd0) $display("FAIL reset_sent: got %0d expected 0", r); else n_pass++;
        bus_read(4'd5, r);
        n_total++; if (r !== 32'd0) $display("FAIL reset_ovf: got %0d expected 0", r); else n_pass++;
        bus_read(4'd1, r);
        n_total++; if (r !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", r); else n_pass++;
        bus_write(4'd7, 32'hFFFF_FFFF);
        bus_read(4'd7, r);
        n_total++; if (r !== 32'd0) $display("FAIL unmapped_read: got %h expected 0", r); else n_pass++;
        bus_read(4'd3, r);
        n_total++; if (r !== 32'd216) $display("FAIL unmapped_write_cpb: got %0d expected 216", r); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        int s;
        do_reset();
        bus_write(4'd3, 32'd4);
        bus_write(4'd1, 32'h2);
        bus_read(4'd1, r);
        n_total++; if (r !== 32'h2) $display("FAIL ctrl_readback: got %h expected 2", r); else n_pass++;
        bus_write(4'd0, 32'hA5);
        s = last_wr + 1;
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h100) $display("FAIL single_level1: got %h expected %h", r, 32'h100); else n_pass++;
        repeat (50) @(posedge clk);
        @(negedge clk);
        n_total++; if (hist[s-1] !== 1'b1) $display("FAIL single_pre_start: got %b expected 1", hist[s-1]); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            n_total++;
            if (hist[s+k] !== frame_bit(8'hA5, k/4))
                $display("FAIL single_frame_c%0d: got %b expected %b", k, hist[s+k], frame_bit(8'hA5, k/4));
            else n_pass++;
        end
        n_total++; if (hist[s+40] !== 1'b1) $display("FAIL single_idle_after: got %b expected 1", hist[s+40]); else n_pass++;
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd1) $display("FAIL single_sent: got %0d expected 1", r); else n_pass++;
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL single_tc: got %h expected 5", r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [7:0]  bytes [3];
        int s;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        do_reset();
        bus_write(4'd3, 32'd2);
        bus_write(4'd1, 32'h2);
        bus_write(4'd0, 32'h00);
        s = last_wr + 1;
        bus_write(4'd0, 32'hFF);
        bus_write(4'd0, 32'h55);
        repeat (70) @(posedge clk);
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 20; k++) begin
                n_total++;
                if (hist[s+20*f+k] !== frame_bit(bytes[f], k/2))
                    $display("FAIL b2b_f%0d_c%0d: got %b expected %b", f, k, hist[s+20*f+k], frame_bit(bytes[f], k/2));
                else n_pass++;
            end
        end
        n_total++; if (hist[s+60] !== 1'b1) $display("FAIL b2b_idle_after: got %b expected 1", hist[s+60]); else n_pass++;
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd3) $display("FAIL b2b_sent: got %0d expected 3", r); else n_pass++;
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL b2b_tstat: got %h expected 5", r); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 17; i++) bus_write(4'd0, 32'(i));
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL disabled_tstat: got %h expected 5", r); else n_pass++;
        bus_read(4'd5, r);
        n_total++; if (r !== 32'd0) $display("FAIL disabled_ovf: got %0d expected 0", r); else n_pass++;
        bus_write(4'd3, 32'd1000);
        bus_write(4'd1, 32'h2);
        for (int i = 0; i < 18; i++) bus_write(4'd0, 32'(8'h40 + i));
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h100A) $display("FAIL full_tstat: got %h expected %h", r, 32'h100A); else n_pass++;
        bus_read(4'd5, r);
        n_total++; if (r !== 32'd1) $display("FAIL full_ovf: got %0d expected 1", r); else n_pass++;
        n_total++; if (TxD !== 1'b0) $display("FAIL full_txd_start: got %b expected 0", TxD); else n_pass++;
    endtask

    task automatic test_midframe();
        logic [31:0] r;
        int s;
        do_reset();
        bus_write(4'd3, 32'd4);
        bus_write(4'd1, 32'h2);
        bus_write(4'd0, 32'hA5);
        s = last_wr + 1;
        bus_write(4'd0, 32'h3C);
        bus_write(4'd0, 32'h0F);
        bus_write(4'd3, 32'd8);
        bus_write(4'd1, 32'h0);
        repeat (55) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            n_total++;
            if (hist[s+k] !== frame_bit(8'hA5, k/4))
                $display("FAIL txen_off_frame_c%0d: got %b expected %b", k, hist[s+k], frame_bit(8'hA5, k/4));
            else n_pass++;
        end
        for (int k = 40; k < 48; k++) begin
            n_total++;
            if (hist[s+k] !== 1'b1) $display("FAIL txen_off_idle_c%0d: got %b expected 1", k, hist[s+k]); else n_pass++;
        end
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h200) $display("FAIL txen_off_tstat: got %h expected %h", r, 32'h200); else n_pass++;
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd1) $display("FAIL txen_off_sent: got %0d expected 1", r); else n_pass++;
        bus_write(4'd6, 32'h0);
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL flush_idle_tstat: got %h expected 5", r); else n_pass++;
        bus_read(4'd3, r);
        n_total++; if (r !== 32'd8) $display("FAIL cpb_readback: got %0d expected 8", r); else n_pass++;

        bus_write(4'd1, 32'h2);
        bus_write(4'd0, 32'h3C);
        s = last_wr + 1;
        bus_write(4'd0, 32'h11);
        bus_write(4'd0, 32'h22);
        bus_write(4'd6, 32'h0);
        bus_read(4'd2, r);
        n_total++; if (r !== 32'hC) $display("FAIL flush_busy_tstat: got %h expected %h", r, 32'hC); else n_pass++;
        repeat (95) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            n_total++;
            if (hist[s+k] !== frame_bit(8'h3C, k/8))
                $display("FAIL newcpb_frame_c%0d: got %b expected %b", k, hist[s+k], frame_bit(8'h3C, k/8));
            else n_pass++;
        end
        for (int k = 80; k < 85; k++) begin
            n_total++;
            if (hist[s+k] !== 1'b1) $display("FAIL flush_no_more_c%0d: got %b expected 1", k, hist[s+k]); else n_pass++;
        end
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd2) $display("FAIL flush_sent: got %0d expected 2", r); else n_pass++;
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL flush_end_tstat: got %h expected 5", r); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        do_reset();
        bus_write(4'd3, 32'd4);
        bus_write(4'd1, 32'h2);
        bus_write(4'd0, 32'h00);
        bus_write(4'd0, 32'h33);
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (TxD !== 1'b0) $display("FAIL pre_reset_data_bit: got %b expected 0", TxD); else n_pass++;
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (TxD !== 1'b1) $display("FAIL abort_txd: got %b expected 1", TxD); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        bus_read(4'd2, r);
        n_total++; if (r !== 32'h5) $display("FAIL abort_tstat: got %h expected 5", r); else n_pass++;
        bus_read(4'd4, r);
        n_total++; if (r !== 32'd0) $display("FAIL abort_sent: got %0d expected 0", r); else n_pass++;
        bus_read(4'd1, r);
        n_total++; if (r !== 32'd0) $display("FAIL abort_ctrl: got %h expected 0", r); else n_pass++;
        bus_read(4'd3, r);
        n_total++; if (r !== 32'd216) $display("FAIL abort_cpb: got %0d expected 216", r); else n_pass++;
        repeat (10) @(posedge clk);
        #1;
        n_total++; if (TxD !== 1'b1) $display("FAIL abort_stays_idle: got %b expected 1", TxD); else n_pass++;
    endtask

    initial begin
        resetn = 1'b0;
        cs     = 1'b0;
        wen    = 1'b0;
        addr   = 4'd0;
        din    = 32'd0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_midframe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
